// File: rtl/gcount_burst_ctl_if.sv
// Harness-facing bundle of the Gray-counter burst sequencer.
// The harness drives through the master modport; the sequencer attaches to slave.
interface gcount_burst_ctl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] run_len;
    logic [7:0]       gap_len;
    logic [7:0]       burst_cnt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_bin;
    logic             cnt_en;
    logic             busy;
    logic             done;
    logic [7:0]       burst_idx;

    modport master (
        output start, abort, run_len, gap_len, burst_cnt,
        input  q, q_bin, cnt_en, busy, done, burst_idx
    );

    modport slave (
        input  start, abort, run_len, gap_len, burst_cnt,
        output q, q_bin, cnt_en, busy, done, burst_idx
    );
endinterface

// File: rtl/gcount_burst_ctl.sv
// Burst sequencer for the power-measurement Gray counter.
// Clears the counter, counts for run_len cycles, idles for gap_len cycles,
// repeats for burst_cnt bursts, then publishes the final count in binary.
// All outputs are registered so activity windows are exactly cycle-bounded.
module gcount_burst_ctl #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    gcount_burst_ctl_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    // Binary to Gray conversion.
    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1'b1);
    endfunction

    // Gray to binary conversion (prefix XOR from the MSB down).
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [2:0]       state_q,     state_d;
    logic [WIDTH-1:0] q_q,         q_d;
    logic [WIDTH-1:0] q_bin_q,     q_bin_d;
    logic [7:0]       burst_idx_q, burst_idx_d;
    logic [WIDTH-1:0] run_cyc_q,   run_cyc_d;
    logic [7:0]       gap_cyc_q,   gap_cyc_d;
    logic [WIDTH-1:0] run_len_q,   run_len_d;
    logic [7:0]       gap_len_q,   gap_len_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;
    logic             cnt_en_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] bin_inc_s;
    logic [7:0]       n_eff_s;
    logic             run_last_s;
    logic             gap_last_s;
    logic             more_s;

    // Derived conditions: next binary count, effective burst count, end-of-phase flags.
    always_comb begin
        bin_inc_s  = gray2bin(q_q) + ONE_W;
        n_eff_s    = (burst_cnt_q == 8'd0) ? 8'd1 : burst_cnt_q;
        run_last_s = (run_cyc_q == (run_len_q - ONE_W));
        gap_last_s = (gap_cyc_q == (gap_len_q - 8'd1));
        more_s     = (({1'b0, burst_idx_q} + 9'd1) < {1'b0, n_eff_s});
    end

    // Sequencer next-state and datapath update; abort wins in every busy state.
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        q_bin_d     = q_bin_q;
        burst_idx_d = burst_idx_q;
        run_cyc_d   = run_cyc_q;
        gap_cyc_d   = gap_cyc_q;
        run_len_d   = run_len_q;
        gap_len_d   = gap_len_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    run_len_d   = bus.run_len;
                    gap_len_d   = bus.gap_len;
                    burst_cnt_d = bus.burst_cnt;
                    state_d     = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    q_d         = '0;
                    burst_idx_d = 8'd0;
                    run_cyc_d   = '0;
                    if (run_len_q == '0) begin
                        // Nothing to count: the final count is the cleared value.
                        q_bin_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    q_d = bin2gray(bin_inc_s);
                    if (run_last_s) begin
                        burst_idx_d = burst_idx_q + 8'd1;
                        run_cyc_d   = '0;
                        gap_cyc_d   = 8'd0;
                        if (!more_s) begin
                            // Snapshot includes the increment taken on this edge.
                            q_bin_d = bin_inc_s;
                            state_d = ST_DONE;
                        end else if (gap_len_q == 8'd0) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        run_cyc_d = run_cyc_q + ONE_W;
                    end
                end
            end
            ST_GAP: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (gap_last_s) begin
                    run_cyc_d = '0;
                    state_d   = ST_RUN;
                end else begin
                    gap_cyc_d = gap_cyc_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            q_q         <= '0;
            q_bin_q     <= '0;
            burst_idx_q <= 8'd0;
            run_cyc_q   <= '0;
            gap_cyc_q   <= 8'd0;
            run_len_q   <= '0;
            gap_len_q   <= 8'd0;
            burst_cnt_q <= 8'd0;
            cnt_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            q_bin_q     <= q_bin_d;
            burst_idx_q <= burst_idx_d;
            run_cyc_q   <= run_cyc_d;
            gap_cyc_q   <= gap_cyc_d;
            run_len_q   <= run_len_d;
            gap_len_q   <= gap_len_d;
            burst_cnt_q <= burst_cnt_d;
            cnt_en_q    <= (state_d == ST_RUN);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign bus.q         = q_q;
    assign bus.q_bin     = q_bin_q;
    assign bus.cnt_en    = cnt_en_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.burst_idx = burst_idx_q;

endmodule

// File: tb/tb_gcount_burst_ctl.sv
// Directed bench for gcount_burst_ctl: a 32-bit instance for most scenarios
// and a 4-bit instance for wrap-around.
module tb_gcount_burst_ctl;

    logic clk;
    logic reset;

    gcount_burst_ctl_if #(.WIDTH(32)) b32 ();
    gcount_burst_ctl_if #(.WIDTH(4))  b4  ();

    gcount_burst_ctl #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    gcount_burst_ctl #(.WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(b4));

    int n_cmp;
    int n_bad;

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one launch; the tick inside is edge E0.
    task automatic launch(input bit w4, input logic [31:0] r, input logic [7:0] g, input logic [7:0] n);
        if (w4) begin
            b4.run_len = r[3:0]; b4.gap_len = g; b4.burst_cnt = n; b4.start = 1'b1;
        end else begin
            b32.run_len = r; b32.gap_len = g; b32.burst_cnt = n; b32.start = 1'b1;
        end
        tick();
        b4.start  = 1'b0;
        b32.start = 1'b0;
    endtask

    // Counts edges (starting at 'first') until done is seen, bounded by max_edges.
    task automatic wait_done(input bit w4, input int first, input int max_edges, input string tag, output int edges);
        bit got;
        got   = 1'b0;
        edges = first;
        for (int i = 0; i < max_edges && !got; i++) begin
            tick();
            edges++;
            got = w4 ? b4.done : b32.done;
        end
        chk({tag, "_done_seen"}, {63'd0, got}, 64'd1);
    endtask

    initial begin
        int          e;
        logic [31:0] v;
        logic [31:0] pat_obs;
        logic [31:0] pat_exp;
        bit          seen;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        b32.start = 1'b0; b32.abort = 1'b0; b32.run_len = 32'd0; b32.gap_len = 8'd0; b32.burst_cnt = 8'd0;
        b4.start  = 1'b0; b4.abort  = 1'b0; b4.run_len  = 4'd0;  b4.gap_len  = 8'd0; b4.burst_cnt  = 8'd0;

        // Reset state.
        #12;
        chk("rst_q", b32.q, 64'd0);
        chk("rst_busy", b32.busy, 64'd0);
        chk("rst_done", b32.done, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Basic count: run 3, one burst.
        launch(1'b0, 32'd3, 8'd0, 8'd1);
        chk("basic_busy_e0", b32.busy, 64'd1);
        tick();
        chk("basic_q_e1", b32.q, 64'd0);
        chk("basic_cnten_e1", b32.cnt_en, 64'd1);
        tick();
        chk("basic_q_e2", b32.q, 64'd1);
        tick();
        chk("basic_q_e3", b32.q, 64'd3);
        tick();
        chk("basic_q_e4", b32.q, 64'd2);
        chk("basic_done_e4", b32.done, 64'd1);
        chk("basic_qbin", b32.q_bin, 64'd3);
        tick();
        chk("basic_done_drop", b32.done, 64'd0);
        chk("basic_busy_drop", b32.busy, 64'd0);
        chk("basic_q_hold", b32.q, 64'd2);

        // Multi-burst: run 4, gap 2, three bursts.
        launch(1'b0, 32'd4, 8'd2, 8'd3);
        pat_obs = 32'd0;
        pat_exp = 32'd0;
        seen    = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            pat_obs[k] = b32.cnt_en;
            pat_exp[k] = (k <= 16) && (((k - 1) % 6) < 4);
            if (k == 5 || k == 6) chk("multi_gap1_q", b32.q, 64'd6);
            if (k == 11 || k == 12) chk("multi_gap2_q", b32.q, 64'd12);
            if (k == 5) chk("multi_idx1", b32.burst_idx, 64'd1);
            if (k == 11) chk("multi_idx2", b32.burst_idx, 64'd2);
            if (k < 17 && b32.done) seen = 1'b1;
        end
        chk("multi_cnten_pattern", pat_obs, pat_exp);
        chk("multi_no_early_done", {63'd0, seen}, 64'd0);
        chk("multi_done_e17", b32.done, 64'd1);
        chk("multi_idx3", b32.burst_idx, 64'd3);
        chk("multi_qbin", b32.q_bin, 64'd12);
        tick();

        // Wrap on the 4-bit instance: 17 mod 16 = 1.
        v = 32'd17;
        launch(1'b1, v, 8'd0, 8'd1);
        wait_done(1'b1, 1, 40, "w4a", e);
        chk("w4a_edges", e, 64'd3);
        chk("w4a_qbin", b4.q_bin, 64'd1);
        chk("w4a_q", b4.q, 64'd1);
        tick();
        // Wrap across bursts with zero gap: 6*3 = 18 mod 16 = 2.
        launch(1'b1, 32'd6, 8'd0, 8'd3);
        wait_done(1'b1, 1, 40, "w4b", e);
        chk("w4b_edges", e, 64'd20);
        chk("w4b_qbin", b4.q_bin, 64'd2);
        chk("w4b_q", b4.q, 64'd3);
        tick();

        // run_len = 0.
        launch(1'b0, 32'd0, 8'd5, 8'd4);
        wait_done(1'b0, 1, 10, "r0", e);
        chk("r0_edges", e, 64'd2);
        chk("r0_qbin", b32.q_bin, 64'd0);
        tick();

        // burst_cnt = 0 behaves as one burst.
        launch(1'b0, 32'd5, 8'd1, 8'd0);
        wait_done(1'b0, 1, 20, "n0", e);
        chk("n0_edges", e, 64'd7);
        chk("n0_qbin", b32.q_bin, 64'd5);
        chk("n0_idx", b32.burst_idx, 64'd1);
        tick();

        // Abort once q reaches gray(10).
        launch(1'b0, 32'd100, 8'd0, 8'd1);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            seen = (b32.q == 32'd15);
        end
        chk("abort_reach_q10", {63'd0, seen}, 64'd1);
        b32.abort = 1'b1;
        tick();
        b32.abort = 1'b0;
        chk("abort_busy", b32.busy, 64'd0);
        chk("abort_q_hold", b32.q, 64'd15);
        chk("abort_qbin_prev", b32.q_bin, 64'd5);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (b32.done) seen = 1'b1;
            tick();
        end
        chk("abort_no_done", {63'd0, seen}, 64'd0);

        // Start while busy is ignored; run_len stays latched.
        launch(1'b0, 32'd6, 8'd0, 8'd1);
        tick();
        tick();
        b32.run_len = 32'd9;
        b32.start   = 1'b1;
        tick();
        b32.start   = 1'b0;
        wait_done(1'b0, 4, 20, "busy_start", e);
        chk("busy_start_edges", e, 64'd8);
        chk("busy_start_qbin", b32.q_bin, 64'd6);
        tick();

        // start and abort together in IDLE.
        b32.start = 1'b1;
        b32.abort = 1'b1;
        tick();
        b32.start = 1'b0;
        b32.abort = 1'b0;
        chk("sa_idle_busy", b32.busy, 64'd0);
        tick();
        chk("sa_idle_busy2", b32.busy, 64'd0);

        // Asynchronous reset asserted mid-GAP, between edges.
        launch(1'b0, 32'd3, 8'd4, 8'd2);
        for (int i = 0; i < 5; i++) tick();
        chk("ar_in_gap_cnten", b32.cnt_en, 64'd0);
        chk("ar_in_gap_busy", b32.busy, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_q", b32.q, 64'd0);
        chk("ar_qbin", b32.q_bin, 64'd0);
        chk("ar_busy", b32.busy, 64'd0);
        chk("ar_idx", b32.burst_idx, 64'd0);
        chk("ar_done", b32.done, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        launch(1'b0, 32'd2, 8'd0, 8'd2);
        wait_done(1'b0, 1, 20, "post_rst", e);
        chk("post_rst_edges", e, 64'd6);
        chk("post_rst_qbin", b32.q_bin, 64'd4);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gcount_burst_ctl.md
# gcount_burst_ctl

Burst sequencer for the power-measurement Gray counter. It owns an enable-gated WIDTH-bit Gray counter and runs it in programmable bursts: clear, count for `run_len` cycles, idle for `gap_len` cycles, repeat `burst_cnt` times. It then reports the final count in binary. It sits between the test harness and the counted datapath, so power activity windows are exactly cycle-bounded and repeatable.

## Interface
- `WIDTH`, 32, counter width; legal range 2..32.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `start`  in  1  launch request; sampled only in IDLE.
- `abort`  in  1  terminate sequence; sampled in any non-IDLE state.
- `run_len`  in  WIDTH  counted cycles per burst; latched on accepted start.
- `gap_len`  in  8  idle cycles between bursts; latched on accepted start.
- `burst_cnt`  in  8  number of bursts; 0 treated as 1; latched on accepted start.
- `q`  out  WIDTH  Gray-coded count, registered.
- `q_bin`  out  WIDTH  binary snapshot of final count, registered.
- `cnt_en`  out  1  high in RUN; q advances at the next edge.
- `busy`  out  1  high in CLEAR, RUN, GAP and DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `burst_idx`  out  8  completed bursts in the current sequence.

## Operation
- Reset (asynchronous, immediate): state=IDLE; q, q_bin, burst_idx = 0; cnt_en, busy, done = 0; latched parameters = 0.
- States: IDLE, CLEAR, RUN, GAP, DONE.
- IDLE:
  - start=1 and abort=0 → CLEAR; run_len, gap_len and burst_cnt are latched.
  - start=1 and abort=1 → start is ignored.
- CLEAR, 1 cycle:
  - q ← 0 and burst_idx ← 0.
  - Latched run_len=0 → DONE; otherwise → RUN.
- RUN:
  - Each cycle, q ← bin2gray(gray2bin(q)+1) mod 2^WIDTH.
  - The cycle counter reloads on entry. After run_len RUN cycles, burst_idx increments.
  - If burst_idx+1 < N, go to GAP, or straight to RUN if gap_len=0. Otherwise go to DONE.
- GAP: q holds. After gap_len cycles → RUN.
- DONE, 1 cycle:
  - done=1.
  - q_bin holds gray2bin(q); it is written on the edge entering DONE, so it is valid while done=1.
  - → IDLE.
- Count accumulates across bursts: final q_bin = (run_len·N) mod 2^WIDTH.
- Wrap-around: gray(2^WIDTH−1) → 0 with no flag.
- abort=1 in CLEAR/RUN/GAP/DONE → IDLE at the next edge. Effects:
  - q holds its current value.
  - q_bin is not updated.
  - No done pulse (DONE in progress: done drops with the state).
  - burst_idx holds.
- start while busy is ignored. Parameter inputs may change freely after acceptance.
- q changes only in CLEAR and RUN, by at most one Gray step (one bit) per cycle. Exception: CLEAR may flip multiple bits.

## Timing
- Start sampled at edge E0 → busy=1 after E0.
- CLEAR clears q at E1. RUN increments occur at E2..E(R+1) for the first burst.
- Edges including E0 until done is visible: 2 + N·R + (N−1)·G.
  - R = latched run_len, N = effective burst count, G = gap_len.
- run_len=0: done is visible after E1 (2 edges); q_bin=0.
- busy falls after the edge leaving DONE.
- A new start is accepted the cycle after DONE, at the earliest.
- Back-to-back run length is minimum 3 + N·R + (N−1)·G edges per sequence.
- Reset deassertion has no synchronizer requirement inside the block. The first active edge after deassertion samples IDLE.

## Test plan
- Basic count, WIDTH=32, run_len=3, burst_cnt=1, start pulse:
  - q sequence 0→1→3→2.
  - done high after 5 edges counting E0.
  - q_bin=3, q=2, busy low the next cycle.
- Multi-burst, run_len=4, gap_len=2, burst_cnt=3:
  - cnt_en pattern 4 on / 2 off / 4 on / 2 off / 4 on.
  - q constant during each gap; burst_idx 1, 2, 3.
  - done after 18 edges; q_bin=12.
- Wrap and degenerate inputs:
  - WIDTH=4, run_len=17 → q_bin=1, q=4'b0001.
  - run_len=0 → done after 2 edges, q_bin=0.
  - burst_cnt=0 behaves as 1.
- Abort: run_len=100; abort at 10th RUN cycle.
  - IDLE next edge; no done pulse; q holds gray(10).
  - q_bin retains the previous sequence's value.
- Protocol corners:
  - start while busy → ignored; latched run_len unchanged when the run_len input changes mid-run.
  - start and abort together in IDLE → stays IDLE.
- Asynchronous reset, asserted mid-GAP between clock edges:
  - All outputs go to their reset values immediately, without a clock.
  - After release, a fresh start runs normally.
